// File: rtl/gear_src_arb.sv
// Frame-level round-robin arbiter feeding the 24->16 gearbox input port.
// Grants one source per frame, registers its words, forces a FILL word on stall.
module gear_src_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned GAP  = 2,
    parameter int unsigned TMO  = 255,
    parameter logic [23:0] FILL = 24'hFFFFFF,
    localparam int unsigned SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk128,
    input  logic                 init_n,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req,
    input  logic [24*NREQ-1:0]   datin,
    input  logic [NREQ-1:0]      davin,
    input  logic [NREQ-1:0]      fstin,
    input  logic [NREQ-1:0]      lstin,
    output logic [NREQ-1:0]      gnt,
    output logic [23:0]          datout,
    output logic                 davout,
    output logic                 fstout,
    output logic                 lstout,
    output logic [SW-1:0]        cur_src,
    output logic                 busy,
    output logic                 tmo_err
);

    localparam int unsigned SW1 = SW + 1;
    localparam int unsigned GW  = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   cur_q, cur_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [23:0]     dat_q, dat_d;
    logic            dav_q, dav_d;
    logic            fst_q, fst_d;
    logic            lst_q, lst_d;
    logic            tmo_q, tmo_d;
    logic            first_q, first_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic              pick_vld;
    logic [SW-1:0]     pick_idx;
    logic [2*NREQ-1:0] req_dbl;
    logic [2*NREQ-1:0] req_rot;
    logic [SW1-1:0]    pick_sum;

    logic [23:0] sel_dat;
    logic        sel_dav;
    logic        sel_lst;
    logic        frame_end;
    logic [16:0] tmo_inc;

    // fstout is derived from the first accepted word of a grant, so fstin is never consulted.
    logic unused_fstin;
    assign unused_fstin = ^fstin;

    // Rotate requests so that bit 0 is the round-robin pointer position.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_sum = '0;
        req_dbl  = {req, req};
        req_rot  = req_dbl >> ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_vld && req_rot[k]) begin
                pick_vld = 1'b1;
                pick_sum = {1'b0, ptr_q} + SW1'(k);
                if (pick_sum >= SW1'(NREQ)) begin
                    pick_sum = pick_sum - SW1'(NREQ);
                end
                pick_idx = pick_sum[SW-1:0];
            end
        end
    end

    always_comb begin
        sel_dat = '0;
        sel_dav = 1'b0;
        sel_lst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (cur_q == SW'(i)) begin
                sel_dat = datin[i*24 +: 24];
                sel_dav = davin[i];
                sel_lst = lstin[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        gnt_d     = gnt_q;
        first_d   = first_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        dat_d     = '0;
        dav_d     = 1'b0;
        fst_d     = 1'b0;
        lst_d     = 1'b0;
        tmo_d     = 1'b0;
        frame_end = 1'b0;
        tmo_inc   = {1'b0, tmo_cnt_q} + 17'd1;

        unique case (state_q)
            StIdle: begin
                if (enable && pick_vld) begin
                    state_d   = StXfer;
                    gnt_d     = NREQ'(1) << pick_idx;
                    cur_d     = pick_idx;
                    tmo_cnt_d = '0;
                    first_d   = 1'b1;
                end
            end
            StXfer: begin
                if (sel_dav) begin
                    dav_d     = 1'b1;
                    dat_d     = sel_dat;
                    fst_d     = first_q;
                    lst_d     = sel_lst;
                    first_d   = 1'b0;
                    tmo_cnt_d = '0;
                    frame_end = sel_lst;
                end else if (tmo_inc == 17'(TMO)) begin
                    // Stalled source: close the frame so the gearbox never waits forever.
                    dav_d     = 1'b1;
                    dat_d     = FILL;
                    fst_d     = first_q;
                    lst_d     = 1'b1;
                    tmo_d     = 1'b1;
                    frame_end = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_inc[15:0];
                end
                if (frame_end) begin
                    state_d   = StGap;
                    gnt_d     = '0;
                    gap_cnt_d = GW'(GAP);
                    ptr_d     = (cur_q == SW'(NREQ - 1)) ? '0 : cur_q + SW'(1);
                end
            end
            StGap: begin
                if (gap_cnt_q <= GW'(1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk128 or negedge init_n) begin
        if (!init_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cur_q     <= '0;
            gnt_q     <= '0;
            first_q   <= 1'b0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            dat_q     <= '0;
            dav_q     <= 1'b0;
            fst_q     <= 1'b0;
            lst_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            gnt_q     <= gnt_d;
            first_q   <= first_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            dat_q     <= dat_d;
            dav_q     <= dav_d;
            fst_q     <= fst_d;
            lst_q     <= lst_d;
            tmo_q     <= tmo_d;
        end
    end

    assign gnt     = gnt_q;
    assign cur_src = cur_q;
    assign datout  = dat_q;
    assign davout  = dav_q;
    assign fstout  = fst_q;
    assign lstout  = lst_q;
    assign tmo_err = tmo_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_gear_src_arb.sv
// Directed bench for gear_src_arb: a frame-level model is checked every cycle,
// and directed scenarios pin key outputs with literal values.
module tb_gear_src_arb;

    localparam int NREQ = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 8;
    localparam logic [23:0] FILL = 24'hFFFFFF;

    logic                 clk128 = 1'b0;
    logic                 init_n = 1'b0;
    logic                 enable = 1'b0;
    logic [NREQ-1:0]      req    = '0;
    logic [24*NREQ-1:0]   datin  = '0;
    logic [NREQ-1:0]      davin  = '0;
    logic [NREQ-1:0]      fstin  = '0;
    logic [NREQ-1:0]      lstin  = '0;
    logic [NREQ-1:0]      gnt;
    logic [23:0]          datout;
    logic                 davout, fstout, lstout, busy, tmo_err;
    logic [1:0]           cur_src;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int order [5] = '{0, 1, 2, 3, 0};

    gear_src_arb #(
        .NREQ(NREQ), .GAP(GAP), .TMO(TMO), .FILL(FILL)
    ) dut (
        .clk128 (clk128),
        .init_n (init_n),
        .enable (enable),
        .req    (req),
        .datin  (datin),
        .davin  (davin),
        .fstin  (fstin),
        .lstin  (lstin),
        .gnt    (gnt),
        .datout (datout),
        .davout (davout),
        .fstout (fstout),
        .lstout (lstout),
        .cur_src(cur_src),
        .busy   (busy),
        .tmo_err(tmo_err)
    );

    always #5 clk128 = ~clk128;
    always @(posedge clk128) cyc <= cyc + 1;

    // Frame-level model: owner of the current frame, gap cycles left, quiet cycles, words seen.
    int m_own   = -1;
    int m_gap   = 0;
    int m_quiet = 0;
    int m_nw    = 0;
    int m_ptr   = 0;
    logic [NREQ-1:0] e_gnt = '0;
    logic [1:0]      e_cur = '0;
    logic [23:0]     e_dat = '0;
    logic            e_dav = 1'b0, e_fst = 1'b0, e_lst = 1'b0, e_tmo = 1'b0, e_busy;

    always @(posedge clk128 or negedge init_n) begin
        int pick;
        logic done;
        if (!init_n) begin
            m_own = -1; m_gap = 0; m_quiet = 0; m_nw = 0; m_ptr = 0;
            e_gnt = '0; e_cur = '0; e_dat = '0;
            e_dav = 1'b0; e_fst = 1'b0; e_lst = 1'b0; e_tmo = 1'b0;
        end else begin
            e_dav = 1'b0; e_fst = 1'b0; e_lst = 1'b0; e_dat = '0; e_tmo = 1'b0;
            done = 1'b0;
            if (m_own >= 0) begin
                if (davin[m_own]) begin
                    e_dav = 1'b1;
                    e_dat = datin[m_own*24 +: 24];
                    e_fst = (m_nw == 0);
                    e_lst = lstin[m_own];
                    m_nw++;
                    m_quiet = 0;
                    done = lstin[m_own];
                end else begin
                    m_quiet++;
                    if (m_quiet == TMO) begin
                        e_dav = 1'b1; e_dat = FILL; e_lst = 1'b1;
                        e_fst = (m_nw == 0); e_tmo = 1'b1; done = 1'b1;
                    end
                end
                if (done) begin
                    m_ptr = (m_own + 1) % NREQ;
                    m_own = -1;
                    m_gap = GAP;
                    e_gnt = '0;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (enable && req != '0) begin
                pick = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (pick < 0 && req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
                end
                m_own = pick; m_nw = 0; m_quiet = 0;
                e_gnt = '0;
                e_gnt[pick] = 1'b1;
                e_cur = 2'(pick);
            end
        end
    end

    always @(negedge clk128) begin
        logic [NREQ+2+24+5-1:0] act, exp;
        e_busy = (m_own >= 0) || (m_gap > 0);
        act = {gnt, cur_src, datout, davout, fstout, lstout, busy, tmo_err};
        exp = {e_gnt, e_cur, e_dat, e_dav, e_fst, e_lst, e_busy, e_tmo};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model cyc=%0d: got gnt/cur/dat/dav/fst/lst/busy/tmo=%h expected %h",
                     cyc, act, exp);
        end
    end

    task automatic step();
        @(posedge clk128);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic dv, input logic f, input logic l,
                         input logic [23:0] d);
        davin[s] = dv;
        fstin[s] = f;
        lstin[s] = l;
        datin[s*24 +: 24] = d;
    endtask

    task automatic idle_all();
        davin = '0; fstin = '0; lstin = '0; datin = '0;
    endtask

    task automatic wait_gnt(output int s);
        s = -1;
        for (int i = 0; i < 40 && s < 0; i++) begin
            for (int k = 0; k < NREQ; k++) if (gnt[k]) s = k;
            if (s < 0) step();
        end
        if (s < 0) begin
            total++;
            bad++;
            $display("FAIL wait_gnt: got no grant expected grant within 40 cycles");
            s = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int s;
        int last_l;
        step();
        step();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_dav", davout, 0);
        init_n = 1'b1;
        enable = 1'b1;

        // single source, 4-word frame
        req = 4'b0100;
        step();
        check("t1_gnt", gnt, 4'b0100);
        check("t1_cur", cur_src, 2);
        for (int w = 1; w <= 4; w++) begin
            drive(2, 1'b1, w == 1, w == 4, 24'(w));
            if (w == 4) req = '0;
            step();
            check("t1_dat", datout, w);
            check("t1_dav", davout, 1);
            check("t1_fst", fstout, w == 1);
            check("t1_lst", lstout, w == 4);
        end
        check("t1_gnt_low", gnt, 0);
        idle_all();
        repeat (4) step();

        // round robin from a fresh pointer
        init_n = 1'b0;
        step();
        init_n = 1'b1;
        req = 4'b1111;
        last_l = -1;
        for (int f = 0; f < 5; f++) begin
            wait_gnt(s);
            check("t2_order", s, order[f]);
            drive(s, 1'b1, 1'b1, 1'b0, 24'(16'h100 + f));
            step();
            check("t2_fst", fstout, 1);
            if (last_l >= 0) check("t2_spacing", cyc - last_l, GAP + 2);
            drive(s, 1'b1, 1'b0, 1'b1, 24'(16'h200 + f));
            step();
            last_l = cyc;
            check("t2_lst", lstout, 1);
            idle_all();
        end

        // single-word frame, then misplaced fst on word 3
        req = 4'b0010;
        wait_gnt(s);
        check("t3_src", s, 1);
        drive(1, 1'b1, 1'b1, 1'b1, 24'hABCDEF);
        step();
        check("t3_dat", datout, 24'hABCDEF);
        check("t3_fstlst", {fstout, lstout}, 2'b11);
        idle_all();
        wait_gnt(s);
        check("t3_src2", s, 1);
        for (int w = 0; w < 4; w++) begin
            drive(1, 1'b1, w == 2, w == 3, 24'(8'h10 + w));
            if (w == 3) req = '0;
            step();
            check("t3_fst_once", fstout, w == 0);
        end
        idle_all();

        // timeout after two words from source 3
        req = 4'b1000;
        wait_gnt(s);
        check("t4_src", s, 3);
        drive(3, 1'b1, 1'b1, 1'b0, 24'h000031);
        step();
        drive(3, 1'b1, 1'b0, 1'b0, 24'h000032);
        step();
        idle_all();
        for (int i = 1; i < TMO; i++) begin
            step();
            check("t4_quiet", davout, 0);
        end
        step();
        check("t4_fill", datout, FILL);
        check("t4_davlst", {davout, lstout, fstout}, 3'b110);
        check("t4_tmo", tmo_err, 1);
        check("t4_gnt", gnt, 0);
        req = 4'b1001;
        step();
        check("t4_tmo_pulse", tmo_err, 0);
        wait_gnt(s);
        check("t4_ptr", s, 0);
        drive(0, 1'b1, 1'b1, 1'b1, 24'h000077);
        req = '0;
        step();
        idle_all();

        // enable gating and masking of non-granted sources
        enable = 1'b0;
        req = 4'b0011;
        repeat (4) step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_nognt", gnt, 0);
            check("t5_idle", busy, 0);
        end
        enable = 1'b1;
        wait_gnt(s);
        check("t5_src", s, 1);
        enable = 1'b0;
        for (int w = 0; w < 3; w++) begin
            drive(1, 1'b1, w == 0, w == 2, 24'(16'h200 + w));
            drive(0, 1'b1, 1'b1, 1'b1, 24'h555555);
            step();
            check("t5_dat", datout, 16'h200 + w);
        end
        idle_all();
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_blocked", gnt, 0);
        end
        check("t5_busy", busy, 0);

        // asynchronous reset mid-frame
        enable = 1'b1;
        req = 4'b0100;
        wait_gnt(s);
        check("t6_src", s, 2);
        drive(2, 1'b1, 1'b1, 1'b0, 24'h0000C1);
        step();
        drive(2, 1'b1, 1'b0, 1'b0, 24'h0000C2);
        #1;
        init_n = 1'b0;
        #1;
        check("t6_rst_gnt", gnt, 0);
        check("t6_rst_out", {datout, davout, fstout, lstout}, 0);
        check("t6_rst_misc", {busy, tmo_err, cur_src}, 0);
        idle_all();
        req = '0;
        @(negedge clk128);
        #2;
        init_n = 1'b1;
        req = 4'b0010;
        wait_gnt(s);
        check("t6_after", gnt, 4'b0010);
        drive(1, 1'b1, 1'b1, 1'b1, 24'h0000D1);
        req = '0;
        step();
        check("t6_word", {fstout, lstout, datout}, {2'b11, 24'h0000D1});
        idle_all();
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
